// File: rtl/mem_wb_skid_stage.sv
// MEM/WB pipeline register with a one-entry skid buffer so in_ready can be registered.
// Also exposes the head entry as a writeback forwarding candidate.
module mem_wb_skid_stage #(
    parameter int ADDR_W       = 5,
    parameter int CTRL_W       = 8,
    parameter int DATA_W       = 32,
    parameter int REGWRITE_BIT = 0,
    parameter int MEMTOREG_BIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_reg_addr,
    input  logic [CTRL_W-1:0] in_control,
    input  logic [DATA_W-1:0] in_memdata,
    input  logic [DATA_W-1:0] in_regdata,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_reg_addr,
    output logic [CTRL_W-1:0] out_control,
    output logic [DATA_W-1:0] out_memdata,
    output logic [DATA_W-1:0] out_regdata,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [CTRL_W-1:0] control;
        logic [DATA_W-1:0] memdata;
        logic [DATA_W-1:0] regdata;
    } entry_t;

    state_t state, state_next;
    entry_t head, skid, in_entry;
    logic   in_ready_q;
    logic   accept, fire;
    logic   load_head_in, load_head_skid, load_skid;

    assign in_entry = '{addr: in_reg_addr, control: in_control,
                        memdata: in_memdata, regdata: in_regdata};
    assign accept   = in_valid && in_ready_q;
    assign fire     = (state != EMPTY) && out_ready;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_next     = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_next   = ONE;
                    load_head_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && fire) begin
                    load_head_in = 1'b1;
                end else if (accept) begin
                    state_next = FULL;
                    load_skid  = 1'b1;
                end else if (fire) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (fire) begin
                    state_next     = ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        // Flush drops both entries and any same-cycle accept; payload is left as-is.
        if (flush) begin
            state_next     = EMPTY;
            load_head_in   = 1'b0;
            load_head_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // NOTE: state and payload use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
            // NOTE: payload is only two entries and must read as zero after reset, so it is reset too.
            head       <= '0;
            skid       <= '0;
        end else begin
            state      <= state_next;
            in_ready_q <= (state_next != FULL);
            if (load_head_in) begin
                head <= in_entry;
            end else if (load_head_skid) begin
                head <= skid;
            end
            if (load_skid) begin
                skid <= in_entry;
            end
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = (state != EMPTY);
    assign occupancy    = state;
    assign out_reg_addr = head.addr;
    assign out_control  = head.control;
    assign out_memdata  = head.memdata;
    assign out_regdata  = head.regdata;

    // Register zero is hardwired, so writes to it are never forwarded.
    assign fwd_valid = out_valid && head.control[REGWRITE_BIT] && (head.addr != '0);
    assign fwd_addr  = head.addr;
    assign fwd_data  = head.control[MEMTOREG_BIT] ? head.memdata : head.regdata;

endmodule

// File: doc/mem_wb_skid_stage.md
MEM_WB_SKID_STAGE -- requirements
Module: mem_wb_skid_stage

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_W, 5, destination register address width.
- CTRL_W, 8, control bundle width.
- DATA_W, 32, memory and ALU data width.
- REGWRITE_BIT, 0, control bit index meaning register write enable.
- MEMTOREG_BIT, 1, control bit index selecting memdata (1) or regdata (0) for writeback.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  sole clock; all state on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept.
- in_reg_addr  in  ADDR_W  destination register.
- in_control  in  CTRL_W  control bundle.
- in_memdata  in  DATA_W  load data.
- in_regdata  in  DATA_W  ALU result.
- flush  in  1  discard all held entries.
- out_valid  out  1  writeback entry valid.
- out_ready  in  1  writeback consumes entry.
- out_reg_addr / out_control / out_memdata / out_regdata  out  ADDR_W / CTRL_W / DATA_W / DATA_W  head entry payload.
- fwd_valid  out  1  forwarding candidate valid.
- fwd_addr  out  ADDR_W  forwarding register address.
- fwd_data  out  DATA_W  forwarding value.
- occupancy  out  2  entries held (0..2).

Function
REQ-003 Storage SHALL be two entries: head (drives out_*) and skid; each holds addr, control, memdata, regdata.
REQ-004 Accept SHALL occur when in_valid && in_ready; fire SHALL occur when out_valid && out_ready.
REQ-005 States SHALL be EMPTY (occ 0), ONE (head only), FULL (head+skid); occupancy SHALL equal state encoding 0/1/2.
REQ-006 Transitions, EMPTY: accept -> ONE, head loads input; else stay.
REQ-007 Transitions, ONE: accept && fire -> ONE, head loads input; accept only -> FULL, skid loads input; fire only -> EMPTY; neither -> stay.
REQ-008 Transitions, FULL: fire -> ONE, head loads skid; no fire -> stay; no accept possible.
REQ-009 in_ready SHALL be a registered signal equal to (next state != FULL); no combinational path from out_ready to in_ready.
REQ-010 out_valid SHALL be 1 exactly in states ONE and FULL.
REQ-011 Latency SHALL be one cycle: entry accepted at edge N appears on out_* with out_valid=1 after edge N when stage was EMPTY, or after head fires.
REQ-012 Entries SHALL leave in acceptance order; no entry duplicated or dropped except by flush or reset.
REQ-013 out_* payload SHALL hold its last value while out_valid=0.
REQ-014 flush=1 SHALL force next state EMPTY and in_ready=1; an accept in the same cycle SHALL be discarded; payload registers not cleared.
REQ-015 fwd_valid SHALL equal out_valid && out_control[REGWRITE_BIT] && (out_reg_addr != 0), combinational from registers.
REQ-016 fwd_addr SHALL equal out_reg_addr; fwd_data SHALL equal out_memdata if out_control[MEMTOREG_BIT] else out_regdata.
REQ-017 Simultaneous flush and fire SHALL count as a fire for downstream but still end in EMPTY.

Reset
REQ-018 rst_n=0 at a clock edge SHALL set state EMPTY, occupancy 0, out_valid 0, in_ready 1, all out_* and skid payload bits 0.
REQ-019 rst_n SHALL take priority over flush and all handshakes; reset mid-transfer SHALL discard both entries.
REQ-020 Outputs SHALL not change between clock edges in response to rst_n (synchronous only).

Verification
REQ-021 Reset then single accept addr=5, control=0x01, regdata=0xDEADBEEF, out_ready=1 -> next cycle out_valid=1, fwd_valid=1, fwd_data=0xDEADBEEF; following cycle EMPTY.
REQ-022 out_ready=0, push A, B -> occupancy 2, in_ready=0, out=A; raise out_ready -> out=B next cycle, then EMPTY; order A,B.
REQ-023 Streaming with out_ready=1 and in_valid=1 for 100 cycles -> one output per cycle, occupancy stays 1, in_ready never 0.
REQ-024 FULL, flush=1 with in_valid=1 -> next cycle occupancy 0, out_valid 0, in_ready 1, flushed input never appears.
REQ-025 control=0x03, memdata=0x12345678, addr=0 -> fwd_valid=0; same with addr=7 -> fwd_valid=1, fwd_data=0x12345678.
REQ-026 rst_n=0 while FULL -> after edge all outputs 0, in_ready 1; rst_n pulse not aligned to an edge -> no output change until edge.
